// File: rtl/reg_load_arbiter_if.sv
// Signal bundle between the four requesters and the shared-register load arbiter.
// The requester side drives req/data; the arbiter side drives the load port and status.
interface reg_load_arbiter_if #(
  parameter int size = 3
);
  logic [3:0]      req;
  logic [size-1:0] data0;
  logic [size-1:0] data1;
  logic [size-1:0] data2;
  logic [size-1:0] data3;
  logic            ld;
  logic [size-1:0] loadData;
  logic [3:0]      grant;
  logic [3:0]      ack;
  logic            busy;
  logic [1:0]      lastOwner;

  modport master (
    output req, data0, data1, data2, data3,
    input  ld, loadData, grant, ack, busy, lastOwner
  );

  modport slave (
    input  req, data0, data1, data2, data3,
    output ld, loadData, grant, ack, busy, lastOwner
  );
endinterface

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter giving four requesters one-cycle access to a shared register's
// load port, followed by a one-cycle acknowledge to the winner.
module reg_load_arbiter #(
  parameter int size = 3
) (
  input logic             clk,
  input logic             rst,
  reg_load_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;

  state_t          state_reg;
  logic [1:0]      owner_reg;
  logic [1:0]      ptr_reg;
  logic [1:0]      last_owner_reg;
  logic            ld_reg;
  logic [3:0]      grant_reg;
  logic [3:0]      ack_reg;
  logic            busy_reg;
  logic [1:0]      pick;
  logic [size-1:0] data_arr [4];

  assign data_arr[0] = bus.data0;
  assign data_arr[1] = bus.data1;
  assign data_arr[2] = bus.data2;
  assign data_arr[3] = bus.data3;

  // Scan from the farthest offset back to ptr so the closest requester wins last.
  always_comb begin
    pick = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[ptr_reg + 2'(k)]) pick = ptr_reg + 2'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 2'd0;
      ptr_reg        <= 2'd0;
      last_owner_reg <= 2'd0;
      ld_reg         <= 1'b0;
      grant_reg      <= 4'd0;
      ack_reg        <= 4'd0;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|bus.req) begin
            state_reg <= LOAD;
            owner_reg <= pick;
            ld_reg    <= 1'b1;
            grant_reg <= 4'b0001 << pick;
            busy_reg  <= 1'b1;
          end
        end
        LOAD: begin
          state_reg <= ACK;
          ld_reg    <= 1'b0;
          ack_reg   <= 4'b0001 << owner_reg;
        end
        ACK: begin
          state_reg      <= IDLE;
          ptr_reg        <= owner_reg + 2'd1;
          last_owner_reg <= owner_reg;
          ack_reg        <= 4'd0;
          grant_reg      <= 4'd0;
          busy_reg       <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Data is muxed live so the owner's value is taken exactly in the LOAD cycle.
  assign bus.loadData  = (state_reg == LOAD) ? data_arr[owner_reg] : '0;
  assign bus.ld        = ld_reg;
  assign bus.grant     = grant_reg;
  assign bus.ack       = ack_reg;
  assign bus.busy      = busy_reg;
  assign bus.lastOwner = last_owner_reg;
endmodule

// File: tb/tb_reg_load_arbiter.sv
// Bench for reg_load_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_reg_load_arbiter;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;
  logic [2:0] reg_q;

  reg_load_arbiter_if #(.size(3)) bus ();

  reg_load_arbiter #(.size(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared register, sharing the arbiter's reset.
  always @(posedge clk) begin
    if (rst) reg_q <= '0;
    else if (bus.ld) reg_q <= bus.loadData;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a transaction takes three cycles (idle sample, load, ack).
  int m_phase = 0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_last  = 0;

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_owner <= 0; m_ptr <= 0; m_last <= 0;
    end else if (m_phase == 0) begin
      if (bus.req != 4'd0) begin
        m_owner <= rr_pick(bus.req, m_ptr);
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      m_phase <= 2;
    end else begin
      m_ptr   <= (m_owner + 1) % 4;
      m_last  <= m_owner;
      m_phase <= 0;
    end
  end

  always @(posedge clk) begin
    logic [2:0]  d [4];
    logic [14:0] exp_v;
    logic [14:0] act_v;
    #1;
    if (chk_en) begin
      d[0] = bus.data0; d[1] = bus.data1; d[2] = bus.data2; d[3] = bus.data3;
      exp_v = {(m_phase == 1) ? 1'b1 : 1'b0,
               (m_phase != 0) ? 4'(1 << m_owner) : 4'd0,
               (m_phase == 2) ? 4'(1 << m_owner) : 4'd0,
               (m_phase != 0) ? 1'b1 : 1'b0,
               2'(m_last),
               (m_phase == 1) ? d[m_owner] : 3'd0};
      act_v = {bus.ld, bus.grant, bus.ack, bus.busy, bus.lastOwner, bus.loadData};
      check("random_outputs", 32'(act_v), 32'(exp_v));
    end
  end

  typedef struct {
    logic [3:0] req;
    logic [2:0] d0, d1, d2, d3;
    int         exp_owner;
    logic [2:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_outputs",
          32'({bus.ld, bus.grant, bus.ack, bus.busy, bus.lastOwner, bus.loadData}), 32'd0);
    check("reset_register", 32'(reg_q), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.data0 = '0; bus.data1 = '0; bus.data2 = '0; bus.data3 = '0;

    // ptr chain after reset: 0 ->3 ->1 ->2 ->0 ->1 ->2 ->3 ->0
    vecs[0] = '{4'b0100, 3'd0, 3'd0, 3'd5, 3'd0, 2, 3'd5};
    vecs[1] = '{4'b0001, 3'd1, 3'd2, 3'd3, 3'd4, 0, 3'd1};
    vecs[2] = '{4'b0010, 3'd1, 3'd2, 3'd3, 3'd4, 1, 3'd2};
    vecs[3] = '{4'b1011, 3'd1, 3'd2, 3'd3, 3'd4, 3, 3'd4};
    vecs[4] = '{4'b1011, 3'd1, 3'd2, 3'd3, 3'd4, 0, 3'd1};
    vecs[5] = '{4'b1011, 3'd6, 3'd7, 3'd3, 3'd4, 1, 3'd7};
    vecs[6] = '{4'b1111, 3'd1, 3'd2, 3'd6, 3'd4, 2, 3'd6};
    vecs[7] = '{4'b1111, 3'd1, 3'd2, 3'd3, 3'd5, 3, 3'd5};

    do_reset();

    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("idle_quiet",
            32'({bus.ld, bus.grant, bus.ack, bus.busy, bus.loadData}), 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      bus.req = vecs[i].req;
      bus.data0 = vecs[i].d0; bus.data1 = vecs[i].d1;
      bus.data2 = vecs[i].d2; bus.data3 = vecs[i].d3;
      @(posedge clk); #1;
      check("vec_load_ld", 32'(bus.ld), 32'd1);
      check("vec_load_grant", 32'(bus.grant), 32'(1 << vecs[i].exp_owner));
      check("vec_load_data", 32'(bus.loadData), 32'(vecs[i].exp_data));
      @(posedge clk); #1;
      check("vec_ack", 32'({bus.ld, bus.ack}), 32'(1 << vecs[i].exp_owner));
      check("vec_register", 32'(reg_q), 32'(vecs[i].exp_data));
      bus.req = '0;
      @(posedge clk); #1;
      check("vec_idle_last", 32'({bus.busy, bus.lastOwner}), 32'(vecs[i].exp_owner));
      $display("vec %0d req=%b owner=%0d data=%0d", i, vecs[i].req, bus.lastOwner, reg_q);
    end

    // Requester 0 drops its request mid-transaction; it must still be served.
    bus.req = 4'b0001;
    bus.data0 = 3'd6;
    @(posedge clk); #1;
    check("drop_load", 32'({bus.ld, bus.grant}), 32'b1_0001);
    bus.req = '0;
    @(posedge clk); #1;
    check("drop_ack", 32'(bus.ack), 32'b0001);
    check("drop_register", 32'(reg_q), 32'd6);
    $display("drop-during-load: ack=%b reg=%0d", bus.ack, reg_q);
    @(posedge clk); #1;

    // Reset lands on the LOAD edge: register must clear, not take 7.
    bus.req = 4'b0010;
    bus.data1 = 3'd7;
    @(posedge clk); #1;
    check("rst_pre_load", 32'({bus.ld, bus.loadData}), 32'b1_111);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_outputs",
          32'({bus.ld, bus.grant, bus.ack, bus.busy, bus.lastOwner, bus.loadData}), 32'd0);
    check("rst_mid_register", 32'(reg_q), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_load", 32'({bus.ld, bus.grant, bus.loadData}), 32'b1_0010_111);
    @(posedge clk); #1;
    check("post_rst_ack", 32'(bus.ack), 32'b0010);
    check("post_rst_register", 32'(reg_q), 32'd7);
    $display("reset-during-load: reg=%0d after retry", reg_q);
    bus.req = '0;

    // All four requesting continuously: 0,1,2,3,0 every three cycles.
    do_reset();
    bus.data0 = 3'd1; bus.data1 = 3'd2; bus.data2 = 3'd3; bus.data3 = 3'd4;
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      check("fair_grant", 32'({bus.ld, bus.grant}), 32'({1'b1, 4'(1 << (t % 4))}));
      @(posedge clk); #1;
      check("fair_register", 32'(reg_q), 32'((t % 4) + 1));
      $display("fair %0d grant owner=%0d reg=%0d", t, t % 4, reg_q);
      @(posedge clk);
    end
    #1;
    bus.req = '0;

    do_reset();
    chk_en = 1;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #2;
      rst = ($urandom_range(0, 59) == 0);
      bus.req = 4'($urandom);
      bus.data0 = 3'($urandom); bus.data1 = 3'($urandom);
      bus.data2 = 3'($urandom); bus.data3 = 3'($urandom);
    end
    @(posedge clk); #2;
    chk_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
